// File: rtl/trace_pkg.sv
// trace_pkg: default geometry and entry layout helpers for the register-write tracer
package trace_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int TS_W_DEF = 16;
  localparam int DEPTH_DEF = 16;
  localparam bit LOG_ALL = 1'b0;
  localparam bit LOG_CHANGE = 1'b1;
  function automatic int entry_w(input int ts_w, input int raddr_w, input int data_w);
    return 1 + ts_w + raddr_w + data_w;
  endfunction
  function automatic int lost_pos(input int ts_w, input int raddr_w, input int data_w);
    return ts_w + raddr_w + data_w;
  endfunction
endpackage

// File: rtl/reg_trace_unit_if.sv
// reg_trace_unit_if: regfile write tap plus trace stream bundle
interface reg_trace_unit_if import trace_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();
  logic rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic trace_en;
  logic [2**RADDR_W-1:0] watch_mask;
  logic trace_valid;
  logic trace_ready;
  logic [entry_w(TS_W, RADDR_W, DATA_W)-1:0] trace_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0] drop_cnt;
  logic overflow;
  modport master (
    output rf_we, rf_waddr, rf_wdata, trace_en, watch_mask, trace_ready,
    input trace_valid, trace_data, fifo_level, drop_cnt, overflow
  );
  modport slave (
    input rf_we, rf_waddr, rf_wdata, trace_en, watch_mask, trace_ready,
    output trace_valid, trace_data, fifo_level, drop_cnt, overflow
  );
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO; pointers carry an extra wrap bit
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q[AW-1:0]] <= din;
  end
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  // zero while empty so the stream never shows stale or uninitialised slots
  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/reg_trace_unit.sv
// reg_trace_unit: captures timestamped regfile writes to watched registers and streams them out
module reg_trace_unit import trace_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter bit CHANGE_ONLY = LOG_ALL
) (
  input logic clk,
  input logic rst,
  reg_trace_unit_if.slave bus
);
  localparam int EW = entry_w(TS_W, RADDR_W, DATA_W);
  localparam int LP = lost_pos(TS_W, RADDR_W, DATA_W);
  localparam int NR = 2**RADDR_W;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [DATA_W-1:0] shadow_q [NR];
  logic [DATA_W-1:0] shadow_d [NR];
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic overflow_q, overflow_d, lost_pend_q, lost_pend_d;
  logic wr_nz, qual, pop, push_ok, drop, full, empty;
  logic [EW-1:0] entry;
  always_comb begin
    wr_nz = bus.rf_we && (bus.rf_waddr != '0);
    qual = wr_nz && bus.trace_en && bus.watch_mask[bus.rf_waddr] &&
           (CHANGE_ONLY != LOG_CHANGE || bus.rf_wdata != shadow_q[bus.rf_waddr]);
    pop = !empty && bus.trace_ready;
    push_ok = qual && (!full || pop);
    drop = qual && full && !pop;
    ts_d = ts_q + 1'b1;
    shadow_d = shadow_q;
    if (wr_nz) shadow_d[bus.rf_waddr] = bus.rf_wdata;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    overflow_d = overflow_q || drop;
    lost_pend_d = drop ? 1'b1 : push_ok ? 1'b0 : lost_pend_q;
    entry = EW'({ts_q, bus.rf_waddr, bus.rf_wdata});
    entry[LP] = lost_pend_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
      shadow_q <= '{default: '0};
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      lost_pend_q <= 1'b0;
    end else begin
      ts_q <= ts_d;
      shadow_q <= shadow_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      lost_pend_q <= lost_pend_d;
    end
  end
  trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_ok),
    .pop(pop),
    .din(entry),
    .dout(bus.trace_data),
    .empty(empty),
    .full(full),
    .level(bus.fifo_level)
  );
  assign bus.trace_valid = !empty;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_reg_trace_unit.sv
// tb_reg_trace_unit: directed scoreboard bench; instance a logs every write, instance b is change-only with a 4-bit timestamp
module tb_reg_trace_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [15:0] tb_ts;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  always #5 clk = ~clk;
  always @(posedge clk) tb_ts <= rst ? 16'd0 : tb_ts + 16'd1;

  reg_trace_unit_if #(.DATA_W(32), .RADDR_W(5), .TS_W(16), .DEPTH(16)) a_if ();
  reg_trace_unit_if #(.DATA_W(32), .RADDR_W(5), .TS_W(4), .DEPTH(16)) b_if ();
  reg_trace_unit #(.DATA_W(32), .RADDR_W(5), .TS_W(16), .DEPTH(16), .CHANGE_ONLY(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  reg_trace_unit #(.DATA_W(32), .RADDR_W(5), .TS_W(4), .DEPTH(16), .CHANGE_ONLY(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  // monitor: every accepted entry must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && a_if.trace_valid && a_if.trace_ready) begin
      if (exp_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_extra got=%h exp=none", a_if.trace_data);
      end else chk("a_entry", 64'(a_if.trace_data), exp_a.pop_front());
    end
    if (!rst && b_if.trace_valid && b_if.trace_ready) begin
      if (exp_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_extra got=%h exp=none", b_if.trace_data);
      end else chk("b_entry", 64'(b_if.trace_data), exp_b.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wa(input logic [4:0] ad, input logic [31:0] d, input bit e, input bit l);
    a_if.rf_we = 1'b1; a_if.rf_waddr = ad; a_if.rf_wdata = d;
    if (e) exp_a.push_back(64'({l, tb_ts, ad, d}));
    cyc();
    a_if.rf_we = 1'b0;
  endtask

  task automatic wb(input logic [4:0] ad, input logic [31:0] d, input bit e, input bit l);
    b_if.rf_we = 1'b1; b_if.rf_waddr = ad; b_if.rf_wdata = d;
    if (e) exp_b.push_back(64'({l, tb_ts[3:0], ad, d}));
    cyc();
    b_if.rf_we = 1'b0;
  endtask

  initial begin
    a_if.rf_we = 0; a_if.rf_waddr = 0; a_if.rf_wdata = 0; a_if.trace_en = 0;
    a_if.watch_mask = 0; a_if.trace_ready = 0;
    b_if.rf_we = 0; b_if.rf_waddr = 0; b_if.rf_wdata = 0; b_if.trace_en = 0;
    b_if.watch_mask = 0; b_if.trace_ready = 0;
    repeat (5) cyc();
    rst = 1'b0;
    chk("rst_valid", 64'(a_if.trace_valid), 0);
    chk("rst_data", 64'(a_if.trace_data), 0);
    chk("rst_level", 64'(a_if.fifo_level), 0);
    chk("rst_drop", 64'(a_if.drop_cnt), 0);
    chk("rst_ovf", 64'(a_if.overflow), 0);
    // T1: single write at ts=3 appears one cycle later
    a_if.trace_en = 1; a_if.watch_mask = 32'h100;
    repeat (3) cyc();
    wa(5'd8, 32'h1234, 1, 0);
    chk("t1_valid", 64'(a_if.trace_valid), 1);
    chk("t1_data", 64'(a_if.trace_data), 64'({1'b0, 16'd3, 5'd8, 32'h1234}));
    chk("t1_level", 64'(a_if.fifo_level), 1);
    a_if.trace_ready = 1;
    cyc();
    chk("t1_drained", 64'(a_if.fifo_level), 0);
    // T3: overflow with consumer stalled, then drain
    a_if.trace_ready = 0; a_if.watch_mask = 32'hFFFF_FFFF;
    for (int i = 0; i < 20; i++) wa(5'(i + 1), 32'(100 + i), i < 16, 0);
    chk("t3_level", 64'(a_if.fifo_level), 16);
    chk("t3_drop", 64'(a_if.drop_cnt), 4);
    chk("t3_ovf", 64'(a_if.overflow), 1);
    a_if.trace_ready = 1;
    wa(5'd21, 32'hABCD, 1, 1);
    repeat (20) cyc();
    chk("t3_empty", 64'(a_if.fifo_level), 0);
    // T4: full with simultaneous pop accepts the push
    a_if.trace_ready = 0;
    for (int i = 0; i < 16; i++) wa(5'(i + 1), 32'(200 + i), 1, 0);
    chk("t4_full", 64'(a_if.fifo_level), 16);
    a_if.trace_ready = 1;
    wa(5'd22, 32'h300, 1, 0);
    chk("t4_level", 64'(a_if.fifo_level), 16);
    chk("t4_drop", 64'(a_if.drop_cnt), 4);
    repeat (20) cyc();
    chk("t4_empty", 64'(a_if.fifo_level), 0);
    // T5: r0, disabled capture and unmasked registers never log
    wa(5'd0, 32'h55, 0, 0);
    chk("t5_r0", 64'(a_if.trace_valid), 0);
    a_if.trace_en = 0;
    wa(5'd3, 32'h66, 0, 0);
    chk("t5_dis", 64'(a_if.trace_valid), 0);
    a_if.trace_en = 1; a_if.watch_mask = ~32'h20;
    wa(5'd5, 32'h77, 0, 0);
    chk("t5_mask", 64'(a_if.trace_valid), 0);
    // T2: change-only suppresses repeated values
    b_if.trace_ready = 1; b_if.trace_en = 1; b_if.watch_mask = 32'h300;
    wb(5'd8, 32'd5, 1, 0);
    wb(5'd8, 32'd5, 0, 0);
    wb(5'd9, 32'd7, 1, 0);
    repeat (3) cyc();
    chk("t2_empty", 64'(b_if.fifo_level), 0);
    // T5 shadow: update while disabled still suppresses an equal value later
    b_if.trace_en = 0;
    wb(5'd9, 32'h77, 0, 0);
    b_if.trace_en = 1;
    wb(5'd9, 32'h77, 0, 0);
    chk("t5_shadow", 64'(b_if.trace_valid), 0);
    wb(5'd9, 32'h78, 1, 0);
    repeat (3) cyc();
    chk("t5_q", 64'(exp_b.size()), 0);
    // T6: timestamp wrap at 4 bits, then reset mid-drain
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_rst_drop", 64'(a_if.drop_cnt), 0);
    chk("t6_rst_ovf", 64'(a_if.overflow), 0);
    b_if.trace_ready = 0;
    repeat (17) cyc();
    wb(5'd9, 32'h99, 1, 0);
    chk("t6_data", 64'(b_if.trace_data), 64'({1'b0, 4'd1, 5'd9, 32'h99}));
    wb(5'd8, 32'd1, 1, 0);
    wb(5'd8, 32'd2, 1, 0);
    chk("t6_level", 64'(b_if.fifo_level), 3);
    b_if.trace_ready = 1;
    cyc();
    rst = 1;
    exp_b.delete();
    cyc();
    chk("t6_valid", 64'(b_if.trace_valid), 0);
    chk("t6_lvl0", 64'(b_if.fifo_level), 0);
    chk("t6_data0", 64'(b_if.trace_data), 0);
    rst = 0;
    repeat (3) cyc();
    chk("a_q_left", 64'(exp_a.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
